cpu_fetch_stage: RTL and testbench
==================================

// Module: cpu_fetch_stage
// PURPOSE
//  Fetch stage of the core: owns the architectural PC, drives the I-TLB/I-cache lookup, and handles miss stalls.
//  Redirects the PC on decode-stage jumps and on exceptions.
//  Registers each fetched instruction into the fetch->decode pipeline register, with valid/stall handshaking.
//  Sits between the I-TLB/I-cache (upstream) and the decode stage (downstream).
// PARAMETERS
//  VADDR_W   32            virtual address width (`VIRTUAL_ADDR_WIDTH)
//  INSTR_W   32            instruction width (`INSTR_WIDTH)
//  BOOT_PC   32'h0000_1000 PC loaded at reset
//  EXC_PC    32'h0000_2000 exception handler entry PC
// PORTS
//  clk            in   1        core clock; all state on rising edge
//  rst_n          in   1        asynchronous, active-low reset
//  ic_req         out  1        lookup request to I-TLB/I-cache, valid this cycle
//  ic_addr        out  VADDR_W  virtual PC being looked up
//  tlb_hit        in   1        I-TLB translation hit for ic_addr (same cycle)
//  cache_hit      in   1        I-cache hit for ic_addr (same cycle)
//  ic_instr       in   INSTR_W  instruction word; valid when tlb_hit&cache_hit
//  jump           in   1        redirect from decode
//  jump_pc        in   VADDR_W  redirect target
//  exception      in   1        pipeline exception flush
//  dec_stall      in   1        decode cannot accept; hold F/D register
//  fd_valid       out  1        F/D register holds a valid instruction
//  fd_instr       out  INSTR_W  fetched instruction
//  fd_pc          out  VADDR_W  PC of fd_instr
//  fd_next_pc     out  VADDR_W  fd_pc+4
//  fetch_fault    out  1        I-TLB miss or misaligned PC; held until exception
//  fault_addr     out  VADDR_W  faulting PC
//  miss_cycles    out  32       saturating count of cycles spent in MISS
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=BOOT_PC; state=RUN; fd_valid=0; fd_instr=0; fd_pc=0; fd_next_pc=0.
//   Also at reset: fetch_fault=0; fault_addr=0; miss_cycles=0.
//   ic_req=0 while rst_n=0. First lookup is at BOOT_PC in the first cycle after deassertion.
//  Lookup: combinational, ic_addr=pc.
//   ic_req=1 in RUN and MISS when the PC is aligned; ic_req=0 in FAULT.
//   Fetch latency: a hit appears in the F/D register on the next rising edge.
//  Priority each cycle: exception > jump > fault/miss handling > dec_stall > normal advance.
//  exception: pc<=EXC_PC; fd_valid<=0; fetch_fault<=0; state<=RUN. Overrides dec_stall and any state.
//  jump (no exception): fd_valid<=0; state<=RUN.
//   jump_pc[1:0]==0: pc<=jump_pc.
//   jump_pc[1:0]!=0: state<=FAULT, fetch_fault<=1, fault_addr<=jump_pc.
//  States:
//   RUN   dec_stall=1: hold pc and F/D (fd_* unchanged, lookup result discarded).
//         tlb_hit=0: state<=FAULT; fetch_fault<=1; fault_addr<=pc; fd_valid<=0 (if !dec_stall).
//         cache_hit=0 (tlb_hit=1): state<=MISS; fd_valid<=0 (if !dec_stall).
//         hit & !dec_stall: fd_valid<=1; fd_instr<=ic_instr; fd_pc<=pc; fd_next_pc<=pc+4; pc<=pc+4.
//   MISS  re-issue same pc each cycle; miss_cycles++ (saturates at 32'hFFFF_FFFF).
//         On hit: same as RUN hit (respects dec_stall: hold F/D, stay RUN, re-lookup).
//         tlb_hit=0 while in MISS: go to FAULT.
//   FAULT no requests; fetch_fault=1; exits only on exception (jump ignored).
//  dec_stall=1 with fd_valid=0: F/D still holds; the bubble persists.
//  PC arithmetic is modulo 2^VADDR_W; pc+4 wraps to 0 with no fault.
//  Simultaneous jump and miss: the jump wins and the in-flight miss is abandoned.
//   A late cache_hit for the old pc is never captured.
//  rst_n asserted mid-miss or mid-fault: returns immediately to the reset state.
// TESTING
//  Reset release, always hit, ic_instr=pc^A5A5A5A5 -> fd_pc: 1000,1004,1008 on consecutive cycles, fd_valid=1.
//  cache_hit=0 for 3 cycles at pc=1008 -> fd_valid=0 for 3 cycles, ic_addr held at 1008.
//   Then 1008 is captured and miss_cycles=3.
//  dec_stall=1 for 2 cycles at fd_pc=1004 -> fd_* unchanged, pc stays 1008; resumes with 1008.
//  jump=1, jump_pc=4000, same cycle as cache_hit=0 -> next cycle fd_valid=0, ic_addr=4000, state RUN.
//  tlb_hit=0 at pc=100C -> fetch_fault=1, fault_addr=100C, ic_req=0.
//   Then exception=1 -> ic_addr=2000, fetch_fault=0.
//  jump_pc=4002 -> fetch_fault=1, fault_addr=4002. pc=FFFFFFFC hit -> fd_next_pc=0, next ic_addr=0.

Source files
------------

// File: rtl/cpu_fetch_stage.sv
// cpu_fetch_stage: PC owner, I-TLB/I-cache lookup, miss/fault handling and F/D register
//   clk, rst_n                      clock, async active-low reset
//   ic_req, ic_addr                 lookup request and PC towards I-TLB/I-cache
//   tlb_hit, cache_hit, ic_instr    same-cycle lookup response
//   jump, jump_pc                   decode-stage redirect
//   exception                       pipeline flush to EXC_PC
//   dec_stall                       decode backpressure, holds F/D register
//   fd_valid, fd_instr, fd_pc, fd_next_pc   F/D pipeline register
//   fetch_fault, fault_addr         sticky fetch fault and faulting PC
//   miss_cycles                     saturating count of cycles spent in MISS
module cpu_fetch_stage #(
  parameter int VADDR_W = 32,
  parameter int INSTR_W = 32,
  parameter logic [VADDR_W-1:0] BOOT_PC = 32'h0000_1000,
  parameter logic [VADDR_W-1:0] EXC_PC  = 32'h0000_2000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               ic_req,
  output logic [VADDR_W-1:0] ic_addr,
  input  logic               tlb_hit,
  input  logic               cache_hit,
  input  logic [INSTR_W-1:0] ic_instr,
  input  logic               jump,
  input  logic [VADDR_W-1:0] jump_pc,
  input  logic               exception,
  input  logic               dec_stall,
  output logic               fd_valid,
  output logic [INSTR_W-1:0] fd_instr,
  output logic [VADDR_W-1:0] fd_pc,
  output logic [VADDR_W-1:0] fd_next_pc,
  output logic               fetch_fault,
  output logic [VADDR_W-1:0] fault_addr,
  output logic [31:0]        miss_cycles
);
  typedef enum logic [1:0] {RUN, MISS, FAULT} state_t;
  state_t state, state_nx;
  logic [VADDR_W-1:0] pc, pc_nx;
  logic active, redirect, jump_ok, aligned, take, fault_set;
  assign aligned  = pc[1:0] == 2'b00;
  assign active   = !exception && state != FAULT;
  // jumps are ignored while faulted; only an exception leaves FAULT
  assign redirect = active && jump;
  assign jump_ok  = jump_pc[1:0] == 2'b00;
  assign take     = active && !jump && aligned && tlb_hit && cache_hit && !dec_stall;
  assign fault_set = active && (jump ? !jump_ok : (!aligned || !tlb_hit));
  assign ic_addr  = pc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RUN;
    else        state <= state_nx;
  always_comb begin
    state_nx = state;
    if (exception) state_nx = RUN;
    else if (state != FAULT)
      state_nx = jump ? (jump_ok ? RUN : FAULT) :
                 (!aligned || !tlb_hit) ? FAULT :
                 !cache_hit ? MISS : RUN;
  end
  always_comb begin
    ic_req = rst_n && state != FAULT && aligned;
  end
  always_comb begin
    pc_nx = exception ? EXC_PC :
            (redirect && jump_ok) ? jump_pc :
            take ? pc + VADDR_W'(4) : pc;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= BOOT_PC;
      fd_valid    <= 1'b0;
      fd_instr    <= '0;
      fd_pc       <= '0;
      fd_next_pc  <= '0;
      fetch_fault <= 1'b0;
      fault_addr  <= '0;
      miss_cycles <= '0;
    end else begin
      pc <= pc_nx;
      // stalled decode keeps the F/D register, bubble included
      if (exception || redirect) fd_valid <= 1'b0;
      else if (take)             fd_valid <= 1'b1;
      else if (active && !dec_stall) fd_valid <= 1'b0;
      if (take) begin
        fd_instr   <= ic_instr;
        fd_pc      <= pc;
        fd_next_pc <= pc + VADDR_W'(4);
      end
      if (exception)      fetch_fault <= 1'b0;
      else if (fault_set) fetch_fault <= 1'b1;
      if (fault_set) fault_addr <= jump ? jump_pc : pc;
      if (state == MISS && !(&miss_cycles)) miss_cycles <= miss_cycles + 32'd1;
    end
  end
endmodule

// File: tb/tb_cpu_fetch_stage.sv
// tb_cpu_fetch_stage: directed self-checking bench for cpu_fetch_stage
module tb_cpu_fetch_stage;
  logic clk = 1'b0, rst_n = 1'b0;
  logic ic_req, tlb_hit, cache_hit, jump, exception, dec_stall;
  logic fd_valid, fetch_fault;
  logic [31:0] ic_addr, ic_instr, jump_pc, fd_instr, fd_pc, fd_next_pc, fault_addr, miss_cycles;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  assign ic_instr = ic_addr ^ 32'hA5A5_A5A5;
  cpu_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .ic_req(ic_req), .ic_addr(ic_addr),
    .tlb_hit(tlb_hit), .cache_hit(cache_hit), .ic_instr(ic_instr),
    .jump(jump), .jump_pc(jump_pc), .exception(exception), .dec_stall(dec_stall),
    .fd_valid(fd_valid), .fd_instr(fd_instr), .fd_pc(fd_pc), .fd_next_pc(fd_next_pc),
    .fetch_fault(fetch_fault), .fault_addr(fault_addr), .miss_cycles(miss_cycles)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    tlb_hit = 1; cache_hit = 1; jump = 0; jump_pc = 0; exception = 0; dec_stall = 0;
    @(negedge clk);
    chk("rst_req", ic_req, 0);
    chk("rst_addr", ic_addr, 32'h1000);
    chk("rst_valid", fd_valid, 0);
    chk("rst_pc", fd_pc, 0);
    chk("rst_npc", fd_next_pc, 0);
    chk("rst_fault", fetch_fault, 0);
    chk("rst_miss", miss_cycles, 0);
    rst_n = 1;
    #1 chk("boot_req", ic_req, 1);
    chk("boot_addr", ic_addr, 32'h1000);
    step();
    chk("f0_valid", fd_valid, 1);
    chk("f0_pc", fd_pc, 32'h1000);
    chk("f0_instr", fd_instr, 32'hA5A5_B5A5);
    chk("f0_npc", fd_next_pc, 32'h1004);
    step();
    chk("f1_pc", fd_pc, 32'h1004);
    chk("f1_addr", ic_addr, 32'h1008);
    cache_hit = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("miss_valid", fd_valid, 0);
      chk("miss_addr", ic_addr, 32'h1008);
      chk("miss_req", ic_req, 1);
    end
    cache_hit = 1;
    step();
    chk("refill_valid", fd_valid, 1);
    chk("refill_pc", fd_pc, 32'h1008);
    chk("refill_cnt", miss_cycles, 3);
    tlb_hit = 0;
    step();
    chk("tlb_fault", fetch_fault, 1);
    chk("tlb_faddr", fault_addr, 32'h100C);
    chk("tlb_req", ic_req, 0);
    chk("tlb_valid", fd_valid, 0);
    jump = 1; jump_pc = 32'h4000;
    step();
    chk("fjmp_fault", fetch_fault, 1);
    chk("fjmp_addr", ic_addr, 32'h100C);
    chk("fjmp_faddr", fault_addr, 32'h100C);
    jump = 0; tlb_hit = 1; exception = 1;
    step();
    exception = 0;
    chk("exc_addr", ic_addr, 32'h2000);
    chk("exc_fault", fetch_fault, 0);
    chk("exc_req", ic_req, 1);
    step();
    chk("exc_fd_pc", fd_pc, 32'h2000);
    dec_stall = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_pc", fd_pc, 32'h2000);
      chk("stall_valid", fd_valid, 1);
      chk("stall_addr", ic_addr, 32'h2004);
    end
    dec_stall = 0;
    step();
    chk("resume_pc", fd_pc, 32'h2004);
    chk("resume_instr", fd_instr, 32'hA5A5_85A1);
    cache_hit = 0; jump = 1; jump_pc = 32'h4000;
    step();
    jump = 0; cache_hit = 1;
    chk("jm_valid", fd_valid, 0);
    chk("jm_addr", ic_addr, 32'h4000);
    step();
    chk("jm_fd_pc", fd_pc, 32'h4000);
    chk("jm_cnt", miss_cycles, 3);
    jump = 1; jump_pc = 32'h4002;
    step();
    jump = 0;
    chk("mis_fault", fetch_fault, 1);
    chk("mis_faddr", fault_addr, 32'h4002);
    chk("mis_req", ic_req, 0);
    exception = 1;
    step();
    exception = 0;
    chk("mis_exc_addr", ic_addr, 32'h2000);
    jump = 1; jump_pc = 32'hFFFF_FFFC;
    step();
    jump = 0;
    chk("wrap_addr", ic_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc", fd_pc, 32'hFFFF_FFFC);
    chk("wrap_npc", fd_next_pc, 0);
    chk("wrap_next", ic_addr, 0);
    chk("wrap_fault", fetch_fault, 0);
    cache_hit = 0;
    step();
    step();
    chk("miss2_cnt", miss_cycles, 4);
    rst_n = 0;
    #1 chk("arst_req", ic_req, 0);
    chk("arst_addr", ic_addr, 32'h1000);
    chk("arst_cnt", miss_cycles, 0);
    chk("arst_valid", fd_valid, 0);
    @(negedge clk);
    rst_n = 1; cache_hit = 1;
    step();
    chk("arst_fd_pc", fd_pc, 32'h1000);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
